multi_mode_trigger_engine: RTL and testbench
============================================

MULTI_MODE_TRIGGER_ENGINE -- requirements
Module: multi_mode_trigger_engine

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 16: number of ADC channels (2..16).
REQ-002 SHALL have parameter ADC_WIDTH, default 12: sample width in bits (8..16).
REQ-003 SHALL have port clk  input  1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port data_in  input  ADC_WIDTH: unsigned sample.
REQ-006 SHALL have port channel_in  input  $clog2(NUM_CHANNELS): sample channel.
REQ-007 SHALL have port data_valid  input  1: sample accepted this cycle.
REQ-008 SHALL have port config_reg  input  8x32: word0 low/level threshold, word1 derivative threshold, word2 hysteresis, word3 channel mask, word4[15:0] holdoff in samples, word5[1:0] mode, word6 window high threshold, word7 reserved.
REQ-009 SHALL have port trigger_valid  output  1: result for the accepted sample.
REQ-010 SHALL have port trigger_out  output  1: trigger fired.
REQ-011 SHALL have port trigger_confidence  output  8: trigger strength.
REQ-012 SHALL have port trigger_metadata  output  16: bits [15:12] channel, [11:10] mode, [9] slope direction (1=rising), [8] reserved 0, [7:0] per-channel fire count.

Function
REQ-013 SHALL use a latency of 1: outputs register the result on the edge after the accepted sample; trigger_valid = registered data_valid.
REQ-014 SHALL implement four modes: 0 level (sample >= word0); 1 derivative (|sample-prev| >= word1); 2 level AND derivative; 3 window (sample < word0 OR sample > word6).
REQ-015 SHALL compute the derivative as a signed value ADC_WIDTH+1 bits wide, with prev being the last accepted sample of the same channel; a channel with no prior sample since reset has derivative condition false.
REQ-016 SHALL compute confidence as the top 8 bits of the ADC_WIDTH-bit excess margin over the firing threshold (derivative margin in modes 1/2); the value is 0 when not firing.
REQ-017 SHALL keep a per-channel FSM: ARMED, then on condition emit trigger -> HOLDOFF (load word4; go to REARM directly if 0); HOLDOFF decrements per accepted sample of that channel and goes to REARM at 0; REARM -> ARMED once the condition is false by the hysteresis margin.
REQ-018 SHALL saturate the hysteresis subtraction at 0 and the addition at full scale.
REQ-019 SHALL, for a masked channel (word3 bit = 0), hold the FSM in ARMED, never fire it, and still update prev.
REQ-020 SHALL, on a change of word5[1:0], force all channels to ARMED with holdoff counters cleared, effective on the next cycle.
REQ-021 SHALL make other config changes take effect on the next accepted sample.
REQ-022 SHALL saturate the fire count at 255.
REQ-023 SHALL clear trigger_out and trigger_confidence when data_valid = 0; metadata holds its last value.

Reset
REQ-024 SHALL, while rst_n = 0, drive all outputs to 0, put every FSM in ARMED, clear holdoff counters, fire counts and prev-valid flags, and discard a sample in flight.

Configuration
REQ-025 SHALL, when TRIG_TIMESTAMP_EN is defined, add output trigger_timestamp (32 bits) carrying a free-running cycle counter (reset 0, wraps) latched at sample acceptance; without TRIG_TIMESTAMP_EN the port and counter SHALL be absent.

Structure
REQ-026 SHALL place the mode enum, FSM state enum, config word indices and metadata field offsets in package trigger_pkg.
REQ-027 SHALL implement per-sample condition/confidence evaluation as combinational sub-module trigger_condition_eval.

Verification (NUM_CHANNELS=16, ADC_WIDTH=12)
REQ-028 SHALL cover: mode 0, word0=2048, word2=256, ch0 ramp 100+200*i for i=0..11 -> exactly one trigger, at 2100, confidence 3.
REQ-029 SHALL cover: mode 1, word1=1024, ch1 samples 500, 500, 2000 -> trigger on 2000 only, confidence 93, metadata[9]=1.
REQ-030 SHALL cover: mode 0, word4=3, word2=0, ch2 samples 3000 x10, then 1000, then 3000 -> triggers on first and last samples, fire count 2.
REQ-031 SHALL cover: word3=0x000F, sample 3000 on ch0..7 -> triggers on ch0..3 only.
REQ-032 SHALL cover: rst_n pulsed low while ch2 is in HOLDOFF -> outputs 0; the first 3000 sample after release triggers.
REQ-033 SHALL cover: with TRIG_TIMESTAMP_EN defined, trigger_timestamp equals the cycle count at sample acceptance.

Source files
------------

// File: rtl/trigger_pkg.sv
// rtl/trigger_pkg.sv - shared types, config word indices and metadata layout for the trigger engine
package trigger_pkg;

   typedef enum logic [1:0] {
      MODE_LEVEL  = 2'd0,
      MODE_DERIV  = 2'd1,
      MODE_BOTH   = 2'd2,
      MODE_WINDOW = 2'd3
   } trig_mode_e;

   typedef enum logic [1:0] {
      ST_ARMED   = 2'd0,
      ST_HOLDOFF = 2'd1,
      ST_REARM   = 2'd2
   } trig_state_e;

   localparam int CFG_LEVEL     = 0;
   localparam int CFG_DERIV     = 1;
   localparam int CFG_HYST      = 2;
   localparam int CFG_MASK      = 3;
   localparam int CFG_HOLDOFF   = 4;
   localparam int CFG_MODE      = 5;
   localparam int CFG_WIN_HI    = 6;
   localparam int CFG_RSVD      = 7;
   localparam int CFG_NUM_WORDS = 8;

   localparam int MD_CH_LSB    = 12;
   localparam int MD_MODE_LSB  = 10;
   localparam int MD_SLOPE_BIT = 9;
   localparam int MD_RSVD_BIT  = 8;
   localparam int MD_CNT_LSB   = 0;

   localparam logic [7:0] FIRE_CNT_MAX = 8'hFF;

endpackage

// File: rtl/trigger_condition_eval.sv
// rtl/trigger_condition_eval.sv - combinational per-sample trigger condition, re-arm test and confidence
module trigger_condition_eval
   import trigger_pkg::*;
#(
   parameter int ADC_WIDTH = 12
) (
   input  logic [ADC_WIDTH-1:0] i_sample,
   input  logic [ADC_WIDTH-1:0] i_prev,
   input  logic                 i_prev_valid,
   input  trig_mode_e           i_mode,
   input  logic [31:0]          i_level_thr,
   input  logic [31:0]          i_deriv_thr,
   input  logic [31:0]          i_hyst,
   input  logic [31:0]          i_win_hi_thr,
   output logic                 o_cond,
   output logic                 o_rearm_ok,
   output logic                 o_slope_rising,
   output logic [7:0]           o_confidence
);

   localparam logic [31:0] FULL_SCALE = {{(32-ADC_WIDTH){1'b0}}, {ADC_WIDTH{1'b1}}};

   function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
      return (a < b) ? 32'd0 : a - b;
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > {1'b0, FULL_SCALE}) ? FULL_SCALE : s[31:0];
   endfunction

   logic [31:0]            w_sample;
   logic [31:0]            w_abs;
   logic [31:0]            w_margin;
   logic [31:0]            w_margin_sat;
   logic [31:0]            w_lvl_lo;
   logic [31:0]            w_der_lo;
   logic [31:0]            w_win_lo;
   logic [31:0]            w_win_hi;
   logic signed [ADC_WIDTH:0] w_diff;
   logic signed [ADC_WIDTH:0] w_neg;
   logic                   w_lvl_hit;
   logic                   w_der_hit;
   logic                   w_below;
   logic                   w_above;

   always_comb begin
      w_sample = {{(32-ADC_WIDTH){1'b0}}, i_sample};
      w_diff   = i_prev_valid ? ($signed({1'b0, i_sample}) - $signed({1'b0, i_prev})) : '0;
      w_neg    = -w_diff;
      w_abs    = {{(32-ADC_WIDTH){1'b0}},
                  (w_diff[ADC_WIDTH] ? w_neg[ADC_WIDTH-1:0] : w_diff[ADC_WIDTH-1:0])};
      o_slope_rising = !w_diff[ADC_WIDTH] && (w_diff != '0);

      w_lvl_hit = (w_sample >= i_level_thr);
      w_der_hit = i_prev_valid && (w_abs >= i_deriv_thr);
      w_below   = (w_sample < i_level_thr);
      w_above   = (w_sample > i_win_hi_thr);

      // re-arm thresholds pull the firing thresholds back toward the quiet region
      w_lvl_lo = sat_sub(i_level_thr, i_hyst);
      w_der_lo = sat_sub(i_deriv_thr, i_hyst);
      w_win_lo = sat_add(i_level_thr, i_hyst);
      w_win_hi = sat_sub(i_win_hi_thr, i_hyst);

      o_cond     = 1'b0;
      o_rearm_ok = 1'b0;
      w_margin   = 32'd0;
      case (i_mode)
         MODE_LEVEL: begin
            o_cond     = w_lvl_hit;
            o_rearm_ok = (w_sample < w_lvl_lo);
            w_margin   = w_sample - i_level_thr;
         end
         MODE_DERIV: begin
            o_cond     = w_der_hit;
            o_rearm_ok = !i_prev_valid || (w_abs < w_der_lo);
            w_margin   = w_abs;
         end
         MODE_BOTH: begin
            o_cond     = w_lvl_hit && w_der_hit;
            o_rearm_ok = (w_sample < w_lvl_lo) || !i_prev_valid || (w_abs < w_der_lo);
            w_margin   = w_abs;
         end
         MODE_WINDOW: begin
            o_cond     = w_below || w_above;
            o_rearm_ok = (w_sample >= w_win_lo) && (w_sample <= w_win_hi);
            w_margin   = w_above ? (w_sample - i_win_hi_thr) : (i_level_thr - w_sample);
         end
         default: ;
      endcase

      w_margin_sat = (w_margin > FULL_SCALE) ? FULL_SCALE : w_margin;
      o_confidence = o_cond ? w_margin_sat[ADC_WIDTH-1 -: 8] : 8'd0;
   end

endmodule

// File: rtl/multi_mode_trigger_engine.sv
// rtl/multi_mode_trigger_engine.sv - per-channel multi-mode ADC trigger with holdoff and hysteresis re-arm
// Optional trigger_timestamp output when TRIG_TIMESTAMP_EN is defined.
module multi_mode_trigger_engine
   import trigger_pkg::*;
#(
   parameter int NUM_CHANNELS = 16,
   parameter int ADC_WIDTH    = 12
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [ADC_WIDTH-1:0]            data_in,
   input  logic [$clog2(NUM_CHANNELS)-1:0] channel_in,
   input  logic                            data_valid,
   input  logic [CFG_NUM_WORDS-1:0][31:0]  config_reg,
   output logic                            trigger_valid,
   output logic                            trigger_out,
   output logic [7:0]                      trigger_confidence,
   output logic [15:0]                     trigger_metadata
`ifdef TRIG_TIMESTAMP_EN
   ,
   output logic [31:0]                     trigger_timestamp
`endif
);

   localparam int CH_W = $clog2(NUM_CHANNELS);

   trig_state_e             r_state [NUM_CHANNELS];
   logic [15:0]             r_hold  [NUM_CHANNELS];
   logic [7:0]              r_cnt   [NUM_CHANNELS];
   logic [ADC_WIDTH-1:0]    r_prev  [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] r_prev_vld;
   trig_mode_e              r_mode_q;

   trig_mode_e  w_mode;
   trig_state_e w_cur_state;
   trig_state_e w_next_state;
   logic [15:0] w_cur_hold;
   logic [15:0] w_next_hold;
   logic [15:0] w_holdoff;
   logic [15:0] w_meta;
   logic [7:0]  w_conf;
   logic [7:0]  w_cnt_next;
   logic        w_mode_chg;
   logic        w_ch_ok;
   logic        w_enabled;
   logic        w_cond;
   logic        w_rearm_ok;
   logic        w_slope;
   logic        w_fire;
   logic        w_unused_cfg;

   assign w_mode      = trig_mode_e'(config_reg[CFG_MODE][1:0]);
   assign w_mode_chg  = (w_mode != r_mode_q);
   assign w_holdoff   = config_reg[CFG_HOLDOFF][15:0];
   assign w_ch_ok     = ({{(32-CH_W){1'b0}}, channel_in} < 32'(NUM_CHANNELS));
   assign w_enabled   = w_ch_ok && config_reg[CFG_MASK][channel_in];
   assign w_cur_state = r_state[channel_in];
   assign w_cur_hold  = r_hold[channel_in];
   assign w_unused_cfg = ^{config_reg[CFG_RSVD], config_reg[CFG_HOLDOFF][31:16],
                           config_reg[CFG_MODE][31:2]};

   trigger_condition_eval #(
      .ADC_WIDTH (ADC_WIDTH)
   ) u_eval (
      .i_sample       (data_in),
      .i_prev         (r_prev[channel_in]),
      .i_prev_valid   (r_prev_vld[channel_in]),
      .i_mode         (w_mode),
      .i_level_thr    (config_reg[CFG_LEVEL]),
      .i_deriv_thr    (config_reg[CFG_DERIV]),
      .i_hyst         (config_reg[CFG_HYST]),
      .i_win_hi_thr   (config_reg[CFG_WIN_HI]),
      .o_cond         (w_cond),
      .o_rearm_ok     (w_rearm_ok),
      .o_slope_rising (w_slope),
      .o_confidence   (w_conf)
   );

   assign w_fire     = data_valid && w_enabled && (w_cur_state == ST_ARMED) && w_cond;
   assign w_cnt_next = (w_fire && (r_cnt[channel_in] != FIRE_CNT_MAX)) ?
                       r_cnt[channel_in] + 8'd1 : r_cnt[channel_in];

   always_comb begin
      w_next_state = w_cur_state;
      w_next_hold  = w_cur_hold;
      if (!w_enabled) begin
         w_next_state = ST_ARMED;
         w_next_hold  = '0;
      end else begin
         case (w_cur_state)
            ST_ARMED: begin
               if (w_cond) begin
                  if (w_holdoff == 16'd0) begin
                     w_next_state = ST_REARM;
                  end else begin
                     w_next_state = ST_HOLDOFF;
                     w_next_hold  = w_holdoff;
                  end
               end
            end
            ST_HOLDOFF: begin
               if (w_cur_hold <= 16'd1) begin
                  w_next_state = ST_REARM;
                  w_next_hold  = '0;
               end else begin
                  w_next_hold = w_cur_hold - 16'd1;
               end
            end
            ST_REARM: begin
               if (w_rearm_ok) w_next_state = ST_ARMED;
            end
            default: w_next_state = ST_ARMED;
         endcase
      end
   end

   always_comb begin
      w_meta                       = '0;
      w_meta[MD_CH_LSB +: 4]       = 4'(channel_in);
      w_meta[MD_MODE_LSB +: 2]     = w_mode;
      w_meta[MD_SLOPE_BIT]         = w_slope;
      w_meta[MD_RSVD_BIT]          = 1'b0;
      w_meta[MD_CNT_LSB +: 8]      = w_cnt_next;
   end

   // a mode switch overrides whatever the current sample would do to the FSMs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            r_state[i] <= ST_ARMED;
            r_hold[i]  <= '0;
         end
      end else if (w_mode_chg) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            r_state[i] <= ST_ARMED;
            r_hold[i]  <= '0;
         end
      end else if (data_valid && w_ch_ok) begin
         r_state[channel_in] <= w_next_state;
         r_hold[channel_in]  <= w_next_hold;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev_vld <= '0;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            r_prev[i] <= '0;
            r_cnt[i]  <= '0;
         end
      end else if (data_valid && w_ch_ok) begin
         r_prev[channel_in]     <= data_in;
         r_prev_vld[channel_in] <= 1'b1;
         r_cnt[channel_in]      <= w_cnt_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode_q           <= MODE_LEVEL;
         trigger_valid      <= 1'b0;
         trigger_out        <= 1'b0;
         trigger_confidence <= '0;
         trigger_metadata   <= '0;
      end else begin
         r_mode_q           <= w_mode;
         trigger_valid      <= data_valid;
         trigger_out        <= w_fire;
         trigger_confidence <= w_fire ? w_conf : 8'd0;
         if (data_valid) trigger_metadata <= w_meta;
      end
   end

`ifdef TRIG_TIMESTAMP_EN
   logic [31:0] r_cycle;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle           <= '0;
         trigger_timestamp <= '0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (data_valid) trigger_timestamp <= r_cycle;
      end
   end
`endif

endmodule

// File: tb/tb_multi_mode_trigger_engine.sv
// tb/tb_multi_mode_trigger_engine.sv - directed and randomized self-checking bench for multi_mode_trigger_engine
module tb_multi_mode_trigger_engine;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [11:0]      data_in;
   logic [3:0]       channel_in;
   logic             data_valid;
   logic [7:0][31:0] config_reg;
   logic             trigger_valid;
   logic             trigger_out;
   logic [7:0]       trigger_confidence;
   logic [15:0]      trigger_metadata;
`ifdef TRIG_TIMESTAMP_EN
   logic [31:0]      trigger_timestamp;
   int               tb_cyc;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) tb_cyc <= 0;
      else        tb_cyc <= tb_cyc + 1;
`endif

   always #5 clk = ~clk;

   multi_mode_trigger_engine #(.NUM_CHANNELS(16), .ADC_WIDTH(12)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .data_in            (data_in),
      .channel_in         (channel_in),
      .data_valid         (data_valid),
      .config_reg         (config_reg),
      .trigger_valid      (trigger_valid),
      .trigger_out        (trigger_out),
      .trigger_confidence (trigger_confidence),
      .trigger_metadata   (trigger_metadata)
`ifdef TRIG_TIMESTAMP_EN
      ,
      .trigger_timestamp  (trigger_timestamp)
`endif
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int          cfg_w0, cfg_w1, cfg_hyst, cfg_hold, cfg_mode, cfg_w6;
   logic [31:0] cfg_mask;
   int          m_prev  [16];
   bit          m_pv    [16];
   bit          m_armed [16];
   int          m_hold  [16];
   int          m_cnt   [16];
   logic [15:0] last_meta;
   logic        obs_fire;
   logic [7:0]  obs_conf;
   logic [15:0] obs_meta;
   logic [11:0] fv;
   int          nfire;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_prev[i] = 0; m_pv[i] = 0; m_armed[i] = 1; m_hold[i] = 0; m_cnt[i] = 0;
      end
      last_meta = 16'h0;
   endtask

   task automatic drive_cfg();
      config_reg    = '0;
      config_reg[0] = 32'(cfg_w0);
      config_reg[1] = 32'(cfg_w1);
      config_reg[2] = 32'(cfg_hyst);
      config_reg[3] = cfg_mask;
      config_reg[4] = 32'(cfg_hold);
      config_reg[5] = 32'(cfg_mode);
      config_reg[6] = 32'(cfg_w6);
   endtask

   task automatic idle(input string tag);
      @(negedge clk);
      data_valid = 1'b0;
      @(posedge clk); #1;
      check({tag, "_valid"}, 32'(trigger_valid), 32'd0);
      check({tag, "_out"},   32'(trigger_out), 32'd0);
      check({tag, "_conf"},  32'(trigger_confidence), 32'd0);
      check({tag, "_meta"},  32'(trigger_metadata), 32'(last_meta));
   endtask

   task automatic apply_cfg(input int w0, input int w1, input int hy, input logic [31:0] mask,
                            input int hold, input int mode, input int w6);
      @(negedge clk);
      data_valid = 1'b0;
      if (mode != cfg_mode)
         for (int i = 0; i < 16; i++) begin m_armed[i] = 1; m_hold[i] = 0; end
      cfg_w0 = w0; cfg_w1 = w1; cfg_hyst = hy; cfg_mask = mask;
      cfg_hold = hold; cfg_mode = mode; cfg_w6 = w6;
      drive_cfg();
      @(posedge clk); #1;
      check("cfg_idle_valid", 32'(trigger_valid), 32'd0);
   endtask

   task automatic send(input int ch, input int s);
      int d, ad, margin, conf, slope, lo_l, lo_d, win_lo, win_hi;
      bit cond, rearm, fire, en;
      logic [15:0] em;
`ifdef TRIG_TIMESTAMP_EN
      int exp_ts;
`endif
      @(negedge clk);
      channel_in = 4'(ch);
      data_in    = 12'(s);
      data_valid = 1'b1;
`ifdef TRIG_TIMESTAMP_EN
      exp_ts = tb_cyc;
`endif
      d      = m_pv[ch] ? s - m_prev[ch] : 0;
      ad     = (d < 0) ? -d : d;
      lo_l   = (cfg_w0 > cfg_hyst) ? cfg_w0 - cfg_hyst : 0;
      lo_d   = (cfg_w1 > cfg_hyst) ? cfg_w1 - cfg_hyst : 0;
      win_lo = (cfg_w0 + cfg_hyst > 4095) ? 4095 : cfg_w0 + cfg_hyst;
      win_hi = (cfg_w6 > cfg_hyst) ? cfg_w6 - cfg_hyst : 0;
      case (cfg_mode)
         0: begin cond = (s >= cfg_w0); margin = s - cfg_w0; rearm = (s < lo_l); end
         1: begin cond = m_pv[ch] && (ad >= cfg_w1); margin = ad; rearm = !m_pv[ch] || (ad < lo_d); end
         2: begin
            cond = (s >= cfg_w0) && m_pv[ch] && (ad >= cfg_w1); margin = ad;
            rearm = (s < lo_l) || !m_pv[ch] || (ad < lo_d);
         end
         default: begin
            cond = (s < cfg_w0) || (s > cfg_w6);
            margin = (s > cfg_w6) ? s - cfg_w6 : cfg_w0 - s;
            rearm = (s >= win_lo) && (s <= win_hi);
         end
      endcase
      en   = cfg_mask[ch];
      fire = en && m_armed[ch] && cond;
      conf = fire ? ((margin > 4095) ? 4095 : margin) / 16 : 0;
      if (fire && m_cnt[ch] < 255) m_cnt[ch]++;
      if (!en) begin
         m_armed[ch] = 1; m_hold[ch] = 0;
      end else if (m_armed[ch]) begin
         if (cond) begin m_armed[ch] = 0; m_hold[ch] = cfg_hold; end
      end else if (m_hold[ch] > 0) begin
         m_hold[ch]--;
      end else if (rearm) begin
         m_armed[ch] = 1;
      end
      m_prev[ch] = s; m_pv[ch] = 1;
      slope = (d > 0) ? 1 : 0;
      em = 16'((ch << 12) | (cfg_mode << 10) | (slope << 9) | m_cnt[ch]);
      @(posedge clk); #1;
      obs_fire = trigger_out; obs_conf = trigger_confidence; obs_meta = trigger_metadata;
      check("valid", 32'(trigger_valid), 32'd1);
      check("fire",  32'(trigger_out), 32'(fire));
      check("conf",  32'(trigger_confidence), 32'(conf));
      check("meta",  32'(trigger_metadata), 32'(em));
`ifdef TRIG_TIMESTAMP_EN
      check("timestamp", trigger_timestamp, 32'(exp_ts));
`endif
      last_meta = em;
   endtask

   initial begin
      rst_n = 1'b0; data_valid = 1'b0; data_in = '0; channel_in = '0;
      cfg_w0 = 2048; cfg_w1 = 1024; cfg_hyst = 256; cfg_mask = 32'hFFFF;
      cfg_hold = 0; cfg_mode = 0; cfg_w6 = 4095;
      drive_cfg();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(trigger_valid), 32'd0);
      check("rst_out",   32'(trigger_out), 32'd0);
      check("rst_conf",  32'(trigger_confidence), 32'd0);
      check("rst_meta",  32'(trigger_metadata), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // level ramp on ch0: a single trigger at 2100
      apply_cfg(2048, 1024, 256, 32'hFFFF, 0, 0, 4095);
      fv = '0;
      for (int i = 0; i < 12; i++) begin
         send(0, 100 + 200 * i);
         fv[i] = obs_fire;
         if (i == 10) check("ramp_conf", 32'(obs_conf), 32'd3);
      end
      check("ramp_fires", 32'(fv), 32'h400);
      idle("ramp_idle");

      // derivative on ch1
      apply_cfg(2048, 1024, 256, 32'hFFFF, 0, 1, 4095);
      fv = '0;
      send(1, 500);  fv[0] = obs_fire;
      send(1, 500);  fv[1] = obs_fire;
      send(1, 2000); fv[2] = obs_fire;
      check("deriv_fires", 32'(fv[2:0]), 32'h4);
      check("deriv_conf",  32'(obs_conf), 32'd93);
      check("deriv_slope", 32'(obs_meta[9]), 32'd1);

      // holdoff then re-arm on ch2
      apply_cfg(2048, 1024, 0, 32'hFFFF, 3, 0, 4095);
      fv = '0;
      for (int i = 0; i < 10; i++) begin send(2, 3000); fv[i] = obs_fire; end
      send(2, 1000); fv[10] = obs_fire;
      send(2, 3000); fv[11] = obs_fire;
      check("holdoff_fires", 32'(fv), 32'h801);
      check("holdoff_count", 32'(obs_meta[7:0]), 32'd2);

      // channel mask; toggle mode first so every channel is armed
      apply_cfg(2048, 1024, 0, 32'hFFFF, 3, 1, 4095);
      apply_cfg(2048, 1024, 0, 32'h000F, 3, 0, 4095);
      fv = '0;
      for (int c = 0; c < 8; c++) begin send(c, 3000); fv[c] = obs_fire; end
      check("mask_fires", 32'(fv[7:0]), 32'h0F);
      idle("mask_idle");

      // reset while ch2 sits in holdoff, with a sample in flight
      apply_cfg(2048, 1024, 0, 32'hFFFF, 5, 0, 4095);
      send(2, 3000);
      send(2, 3000);
      check("pre_rst_holdoff", 32'(obs_fire), 32'd0);
      @(negedge clk);
      channel_in = 4'd2; data_in = 12'd3000; data_valid = 1'b1; rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(trigger_valid), 32'd0);
      check("async_rst_meta",  32'(trigger_metadata), 32'd0);
      @(posedge clk); #1;
      check("rst_hold_out",   32'(trigger_out), 32'd0);
      check("rst_hold_valid", 32'(trigger_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; data_valid = 1'b0;
      model_reset();
      send(2, 3000);
      check("post_rst_fire",  32'(obs_fire), 32'd1);
      check("post_rst_count", 32'(obs_meta[7:0]), 32'd1);

      // fire-count saturation on ch5
      apply_cfg(2048, 1024, 0, 32'hFFFF, 0, 0, 4095);
      nfire = 0;
      for (int i = 0; i < 260; i++) begin
         send(5, 3000); nfire += int'(obs_fire);
         send(5, 1000);
      end
      check("sat_fires", 32'(nfire), 32'd260);
      check("sat_count", 32'(obs_meta[7:0]), 32'd255);

      // randomized configurations and samples
      for (int b = 0; b < 8; b++) begin
         int w0, w6;
         w0 = int'($urandom_range(300, 3800));
         w6 = int'($urandom_range(w0, 4095));
         apply_cfg(w0, int'($urandom_range(0, 2000)), int'($urandom_range(0, 700)),
                   {$urandom_range(0, 65535)} | 32'h3, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), w6);
         for (int k = 0; k < 50; k++) begin
            if ($urandom_range(0, 7) == 0) idle("rand_idle");
            else send(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
